// File: rtl/wb_pkg.sv
// Shared constants and helpers for the writeback arbiter and the issue stage.
package wb_pkg;

    localparam int WB_NUM_CH = 3;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DEPTH  = 2;

    // Ceiling log2; wb_clog2(1) is 0, so callers guard single-entry cases.
    function automatic int wb_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // A buffered entry is packed as {regdest, wbvalue}.
    function automatic int wb_entry_w(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-channel synchronous FIFO holding pending writeback entries.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? wb_clog2(DEPTH) : 1,
    localparam int CNT_W = wb_clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign dout     = r_mem[r_rdPtr];
    assign w_doPush = push && !full;
    assign w_doPop  = pop && !empty;

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_doPush && w_doPop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Buffered round-robin writeback arbiter: NUM_CH functional-unit channels
// share the single register-file write port.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_CH = WB_NUM_CH,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH,
    localparam int CH_IDX_W = (NUM_CH > 1) ? wb_clog2(NUM_CH) : 1,
    localparam int ENTRY_W  = wb_entry_w(ADDR_W, DATA_W),
    localparam int CNT_W    = wb_clog2(DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_oper,
    input  logic [NUM_CH-1:0]          ch_writereg,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_regdest,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wbvalue,
    output logic [NUM_CH-1:0]          ch_ready,
    output logic                       wb_reg_en,
    output logic [ADDR_W-1:0]          wb_reg_addr,
    output logic [DATA_W-1:0]          wb_reg_data,
    output logic [CH_IDX_W-1:0]        wb_grant_ch,
    output logic                       wb_busy,
    output logic                       wb_overflow
);

    logic [NUM_CH-1:0]   w_push;
    logic [NUM_CH-1:0]   w_pop;
    logic [NUM_CH-1:0]   w_full;
    logic [NUM_CH-1:0]   w_empty;
    logic [ENTRY_W-1:0]  w_dout [NUM_CH];
    logic [CNT_W-1:0]    w_count [NUM_CH];
    logic                w_found;
    logic [CH_IDX_W-1:0] w_winner;
    logic [CH_IDX_W-1:0] w_nextRr;
    logic [ENTRY_W-1:0]  w_head;

    logic                r_regEn;
    logic [ADDR_W-1:0]   r_regAddr;
    logic [DATA_W-1:0]   r_regData;
    logic [CH_IDX_W-1:0] r_grantCh;
    logic [CH_IDX_W-1:0] r_rrPtr;
    logic                r_overflow;

    // Results with no destination (writereg low or r0) are consumed but never buffered.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ADDR_W-1:0] w_dest;
        assign w_dest      = ch_regdest[i*ADDR_W +: ADDR_W];
        assign ch_ready[i] = (w_count[i] < CNT_W'(DEPTH));
        assign w_push[i]   = ch_oper[i] && ch_ready[i] && ch_writereg[i] && (w_dest != '0);

        wb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (w_push[i]),
            .pop   (w_pop[i]),
            .din   ({w_dest, ch_wbvalue[i*DATA_W +: DATA_W]}),
            .dout  (w_dout[i]),
            .count (w_count[i]),
            .full  (w_full[i]),
            .empty (w_empty[i])
        );
    end

    // First non-empty channel at or after the round-robin pointer wins.
    always_comb begin
        logic [CH_IDX_W:0] cand;
        cand     = '0;
        w_found  = 1'b0;
        w_winner = '0;
        w_pop    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = {1'b0, r_rrPtr} + (CH_IDX_W+1)'(k);
            if (cand >= (CH_IDX_W+1)'(NUM_CH)) begin
                cand = cand - (CH_IDX_W+1)'(NUM_CH);
            end
            if (!w_found && !w_empty[cand[CH_IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = cand[CH_IDX_W-1:0];
            end
        end
        w_pop[w_winner] = w_found;
    end

    assign w_nextRr = (w_winner == CH_IDX_W'(NUM_CH - 1)) ? '0 : w_winner + 1'b1;
    assign w_head   = w_dout[w_winner];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_regEn    <= 1'b0;
            r_regAddr  <= '0;
            r_regData  <= '0;
            r_grantCh  <= '0;
            r_rrPtr    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_regEn <= w_found;
            if (w_found) begin
                r_regAddr <= w_head[ENTRY_W-1 -: ADDR_W];
                r_regData <= w_head[DATA_W-1:0];
                r_grantCh <= w_winner;
                r_rrPtr   <= w_nextRr;
            end
            if (|(ch_oper & w_full)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign wb_reg_en   = r_regEn;
    assign wb_reg_addr = r_regAddr;
    assign wb_reg_data = r_regData;
    assign wb_grant_ch = r_grantCh;
    assign wb_busy     = ~(&w_empty);
    assign wb_overflow = r_overflow;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised bench for wb_arbiter against a queue-based reference of the
// channel buffering and round-robin write-port rules.
module tb_wb_arbiter;

    localparam int NUM_CH   = 3;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 2;
    localparam int CH_IDX_W = $clog2(NUM_CH);
    localparam int ENTRY_W  = ADDR_W + DATA_W;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_CH-1:0]         ch_oper = '0;
    logic [NUM_CH-1:0]         ch_writereg = '0;
    logic [NUM_CH*ADDR_W-1:0]  ch_regdest = '0;
    logic [NUM_CH*DATA_W-1:0]  ch_wbvalue = '0;
    logic [NUM_CH-1:0]         ch_ready;
    logic                      wb_reg_en;
    logic [ADDR_W-1:0]         wb_reg_addr;
    logic [DATA_W-1:0]         wb_reg_data;
    logic [CH_IDX_W-1:0]       wb_grant_ch;
    logic                      wb_busy;
    logic                      wb_overflow;

    always #5 clock = ~clock;

    wb_arbiter #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ch_oper     (ch_oper),
        .ch_writereg (ch_writereg),
        .ch_regdest  (ch_regdest),
        .ch_wbvalue  (ch_wbvalue),
        .ch_ready    (ch_ready),
        .wb_reg_en   (wb_reg_en),
        .wb_reg_addr (wb_reg_addr),
        .wb_reg_data (wb_reg_data),
        .wb_grant_ch (wb_grant_ch),
        .wb_busy     (wb_busy),
        .wb_overflow (wb_overflow)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    logic [ENTRY_W-1:0]  modelQ [NUM_CH][$];
    int                  modelRr;
    logic                expEn;
    logic [ADDR_W-1:0]   expAddr;
    logic [DATA_W-1:0]   expData;
    logic [CH_IDX_W-1:0] expGrant;
    logic                expOverflow;

    logic [NUM_CH*ADDR_W-1:0] dv;
    logic [NUM_CH*DATA_W-1:0] vv;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [NUM_CH-1:0] modelReady();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) begin
            r[i] = (modelQ[i].size() < DEPTH);
        end
        return r;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < NUM_CH; i++) begin
            modelQ[i].delete();
        end
        modelRr     = 0;
        expEn       = 1'b0;
        expAddr     = '0;
        expData     = '0;
        expGrant    = '0;
        expOverflow = 1'b0;
    endtask

    // One rising edge: grant decided on pre-edge occupancy, then accepted results enqueued.
    task automatic modelEdge();
        logic [NUM_CH-1:0]  rdy;
        logic [ENTRY_W-1:0] e;
        logic [ADDR_W-1:0]  d;
        int                 win;
        int                 c;
        rdy = modelReady();
        win = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (modelRr + k) % NUM_CH;
            if (win < 0 && modelQ[c].size() > 0) win = c;
        end
        if (win >= 0) begin
            e        = modelQ[win].pop_front();
            expEn    = 1'b1;
            expAddr  = e[ENTRY_W-1 -: ADDR_W];
            expData  = e[DATA_W-1:0];
            expGrant = CH_IDX_W'(win);
            modelRr  = (win + 1) % NUM_CH;
        end else begin
            expEn = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            d = ch_regdest[i*ADDR_W +: ADDR_W];
            if (ch_oper[i]) begin
                if (!rdy[i]) expOverflow = 1'b1;
                else if (ch_writereg[i] && d != '0)
                    modelQ[i].push_back({d, ch_wbvalue[i*DATA_W +: DATA_W]});
            end
        end
    endtask

    task automatic compareAll();
        logic busy;
        busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (modelQ[i].size() > 0) busy = 1'b1;
        end
        checkOutput("wb_reg_en",   64'(wb_reg_en),   64'(expEn));
        checkOutput("wb_reg_addr", 64'(wb_reg_addr), 64'(expAddr));
        checkOutput("wb_reg_data", 64'(wb_reg_data), 64'(expData));
        checkOutput("wb_grant_ch", 64'(wb_grant_ch), 64'(expGrant));
        checkOutput("wb_busy",     64'(wb_busy),     64'(busy));
        checkOutput("ch_ready",    64'(ch_ready),    64'(modelReady()));
        checkOutput("wb_overflow", 64'(wb_overflow), 64'(expOverflow));
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] oper, input logic [NUM_CH-1:0] wr,
                                 input logic [NUM_CH*ADDR_W-1:0] dest, input logic [NUM_CH*DATA_W-1:0] val);
        ch_oper     = oper;
        ch_writereg = wr;
        ch_regdest  = dest;
        ch_wbvalue  = val;
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) applyStimulus('0, '0, '0, '0);
    endtask

    task automatic randomCycles(input int n, input bit honour);
        logic [NUM_CH-1:0] op;
        logic [NUM_CH-1:0] wr;
        for (int c = 0; c < n; c++) begin
            op = NUM_CH'($urandom);
            wr = NUM_CH'($urandom | $urandom);
            if (honour) op &= modelReady();
            for (int i = 0; i < NUM_CH; i++) begin
                dv[i*ADDR_W +: ADDR_W] = ($urandom_range(0, 7) == 0) ? '0
                                       : ADDR_W'($urandom_range(1, (1 << ADDR_W) - 1));
                vv[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            applyStimulus(op, wr, dv, vv);
        end
    endtask

    initial begin
        resetModel();
        #1;
        compareAll();
        @(negedge clock);
        reset = 1'b1;
        compareAll();

        // Single write on channel 1.
        dv = '0; vv = '0;
        dv[1*ADDR_W +: ADDR_W] = 5'd7;
        vv[1*DATA_W +: DATA_W] = 32'hDEADBEEF;
        applyStimulus(3'b010, 3'b010, dv, vv);
        idleCycles(3);

        // Drop rules: r0 destination on ch0, writereg low on ch2.
        dv = '0; vv = '0;
        dv[2*ADDR_W +: ADDR_W] = 5'd9;
        vv[0 +: DATA_W]        = 32'h11111111;
        vv[2*DATA_W +: DATA_W] = 32'h22222222;
        applyStimulus(3'b101, 3'b001, dv, vv);
        idleCycles(2);

        // Two simultaneous bursts on all channels.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                dv[i*ADDR_W +: ADDR_W] = ADDR_W'(i + 1);
                vv[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            applyStimulus(3'b111, 3'b111, dv, vv);
            idleCycles(4);
        end

        // Saturate every channel until ready drops and results overflow.
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                dv[i*ADDR_W +: ADDR_W] = ADDR_W'(10 + 3 * c + i);
                vv[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            applyStimulus(3'b111, 3'b111, dv, vv);
        end
        idleCycles(8);

        randomCycles(300, 1'b1);
        randomCycles(200, 1'b0);

        // Fill ch0/ch1, then reset asynchronously between edges.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                dv[i*ADDR_W +: ADDR_W] = ADDR_W'(20 + i);
                vv[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            applyStimulus(3'b011 & modelReady(), 3'b011, dv, vv);
        end
        ch_oper = '0; ch_writereg = '0; ch_regdest = '0; ch_wbvalue = '0;
        #2;
        reset = 1'b0;
        #1;
        resetModel();
        compareAll();
        @(negedge clock);
        reset = 1'b1;
        compareAll();
        idleCycles(5);

        randomCycles(300, 1'b1);
        idleCycles(10);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
